counter_run_controller: RTL and testbench

Command-driven run controller for the lab's binary up counter datapath. It accepts START/STOP/STEP/CLEAR commands over a valid/ready handshake, prescales the clock into count ticks, and applies a programmable terminal value. Counting is either free-running (wrap) or one-shot (halt at limit). It sits between a button/switch front-end and the 7-seg/LED display of q.

---
 rtl/counter_ctrl_pkg.sv | 22 ++
 rtl/counter_run_controller_if.sv | 35 +++
 rtl/counter_core.sv | 34 +++
 rtl/counter_run_controller.sv | 139 +++++++++++++
 tb/tb_counter_run_controller.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and defaults for the counter run controller.
// Command encodings, FSM states and default widths.
package counter_ctrl_pkg;

  localparam int WIDTH_DEF      = 4;
  localparam int PRESCALE_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_STOP  = 2'b01,
    OP_STEP  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

endpackage

// File: rtl/counter_run_controller_if.sv
// Command channel of the counter run controller.
// Master issues commands and config; slave returns cmd_ready.
interface counter_run_controller_if
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [WIDTH-1:0]      cfg_limit;
  logic [PRESCALE_W-1:0] cfg_div;
  logic                  cfg_oneshot;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cfg_limit,
    output cfg_div,
    output cfg_oneshot,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cfg_limit,
    input  cfg_div,
    input  cfg_oneshot,
    output cmd_ready
  );

endinterface

// File: rtl/counter_core.sv
// Count register with clear, increment and limit compare.
// Wraps to zero from the limit or from all ones.
module counter_core
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_limit,
  output logic [WIDTH-1:0] o_q,
  output logic             o_at_limit,
  output logic             o_at_max
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc) begin
      r_q <= o_at_limit ? '0 : r_q + 1'b1;
    end
  end

  assign o_q        = r_q;
  assign o_at_limit = (r_q == i_limit);
  assign o_at_max   = &r_q;

endmodule

// File: rtl/counter_run_controller.sv
// Command-driven run controller for a prescaled up counter.
// Optional sticky irq output when COUNTER_IRQ_EN is defined.
module counter_run_controller
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  counter_run_controller_if.slave cmd,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             wrap,
  output logic             done
`ifdef COUNTER_IRQ_EN
  ,
  output logic             irq
`endif
);

  state_t                r_state;
  state_t                w_nstate;
  logic                  r_hold;
  logic [WIDTH-1:0]      r_limit;
  logic [PRESCALE_W-1:0] r_div;
  logic [PRESCALE_W-1:0] r_pre;
  logic                  r_oneshot;
  logic                  r_wrap;

  logic w_acc;
  op_t  w_op;
  logic w_tick;
  logic w_start;
  logic w_stop;
  logic w_step;
  logic w_clear;
  logic w_done_ev;
  logic w_at_limit;
  logic w_at_max;
  logic w_clr_q;
  logic w_inc;
  logic w_wrap_ev;
  logic w_pre_clr;
  logic w_pre_inc;

  assign w_acc = cmd.cmd_valid & cmd.cmd_ready;
  assign w_op  = op_t'(cmd.cmd_op);

  // An accepted command swallows a tick landing in the same cycle
  assign w_tick = (r_state == RUN)
                & (r_pre == r_div)
                & ~w_acc;

  assign w_start = w_acc & (w_op == OP_START)
                 & (r_state != RUN);
  assign w_stop  = w_acc & (w_op == OP_STOP)
                 & (r_state == RUN);
  assign w_step  = w_acc & (w_op == OP_STEP)
                 & ((r_state == IDLE) | (r_state == PAUSE));
  assign w_clear = w_acc & (w_op == OP_CLEAR);

  assign w_done_ev = w_tick & w_at_limit & r_oneshot;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (1'b1)
      w_clear:   w_nstate = IDLE;
      w_start:   w_nstate = RUN;
      w_stop:    w_nstate = PAUSE;
      w_done_ev: w_nstate = DONE;
      default:   w_nstate = r_state;
    endcase
  end

  always_comb begin
    w_clr_q   = w_clear | (w_start & (r_state != PAUSE));
    w_inc     = w_step | (w_tick & ~w_done_ev);
    w_wrap_ev = w_inc & (w_at_limit | w_at_max);
    w_pre_clr = w_clear | w_start | w_tick;
    w_pre_inc = (r_state == RUN) & ~w_acc & ~w_tick;
    busy          = (r_state == RUN);
    done          = (r_state == DONE);
    wrap          = r_wrap;
    cmd.cmd_ready = ~r_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold    <= 1'b0;
      r_wrap    <= 1'b0;
      r_limit   <= '1;
      r_div     <= '0;
      r_oneshot <= 1'b0;
      r_pre     <= '0;
    end else begin
      r_hold <= w_acc;
      r_wrap <= w_wrap_ev;
      if (w_start) begin
        r_limit   <= cmd.cfg_limit;
        r_div     <= cmd.cfg_div;
        r_oneshot <= cmd.cfg_oneshot;
      end
      if (w_pre_clr)      r_pre <= '0;
      else if (w_pre_inc) r_pre <= r_pre + 1'b1;
    end
  end

  counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr_q),
    .i_inc     (w_inc),
    .i_limit   (r_limit),
    .o_q       (q),
    .o_at_limit(w_at_limit),
    .o_at_max  (w_at_max)
  );

`ifdef COUNTER_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (rst)                         r_irq <= 1'b0;
    else if (w_wrap_ev | w_done_ev)  r_irq <= 1'b1;
    else if (w_clear)                r_irq <= 1'b0;
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_counter_run_controller.sv
// Bench for counter_run_controller: vector table, directed
// corner sequences and random commands against a model.
module tb_counter_run_controller;

  localparam int W    = 4;
  localparam int P    = 8;
  localparam int QMOD = 1 << W;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic clk;
  logic rst;
  logic [W-1:0] q;
  logic busy;
  logic wrap;
  logic done;
`ifdef COUNTER_IRQ_EN
  logic irq;
`endif

  counter_run_controller_if #(.WIDTH(W), .PRESCALE_W(P)) cif ();

  counter_run_controller #(
    .WIDTH(W),
    .PRESCALE_W(P)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cmd (cif),
    .q   (q),
    .busy(busy),
    .wrap(wrap),
    .done(done)
`ifdef COUNTER_IRQ_EN
    ,
    .irq (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state, integers only
  int m_st, m_q, m_pre, m_lim, m_div, m_one;
  int m_rdy, m_wrap, m_irq;

  task automatic bump();
    if (m_q == m_lim) begin
      m_q    = 0;
      m_wrap = 1;
    end else begin
      m_q = (m_q + 1) % QMOD;
      if (m_q == 0) m_wrap = 1;
    end
    if (m_wrap == 1) m_irq = 1;
  endtask

  task automatic model_step();
    bit acc;
    if (rst) begin
      m_st = S_IDLE; m_q = 0; m_pre = 0;
      m_lim = QMOD - 1; m_div = 0; m_one = 0;
      m_rdy = 1; m_wrap = 0; m_irq = 0;
      return;
    end
    acc    = cif.cmd_valid && (m_rdy == 1);
    m_rdy  = acc ? 0 : 1;
    m_wrap = 0;
    if (acc) begin
      case (cif.cmd_op)
        2'd0: if (m_st != S_RUN) begin
          if (m_st != S_PAUSE) m_q = 0;
          m_st  = S_RUN;
          m_pre = 0;
          m_lim = int'(cif.cfg_limit);
          m_div = int'(cif.cfg_div);
          m_one = int'(cif.cfg_oneshot);
        end
        2'd1: if (m_st == S_RUN) m_st = S_PAUSE;
        2'd2: if (m_st == S_IDLE || m_st == S_PAUSE) bump();
        default: begin
          m_st = S_IDLE; m_q = 0; m_pre = 0; m_irq = 0;
        end
      endcase
    end else if (m_st == S_RUN) begin
      if (m_pre == m_div) begin
        m_pre = 0;
        if (m_q == m_lim && m_one == 1) begin
          m_st  = S_DONE;
          m_irq = 1;
        end else begin
          bump();
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
  endtask

  task automatic drive(input bit r, input bit v,
                       input logic [1:0] op,
                       input logic [W-1:0] lim,
                       input logic [P-1:0] dv,
                       input bit one);
    rst             = r;
    cif.cmd_valid   = v;
    cif.cmd_op      = op;
    cif.cfg_limit   = lim;
    cif.cfg_div     = dv;
    cif.cfg_oneshot = one;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic expect_eq(input string nm, input int act,
                           input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_model(input int cyc_no);
    int eb, ed, ei, ai;
    eb = (m_st == S_RUN)  ? 1 : 0;
    ed = (m_st == S_DONE) ? 1 : 0;
    ei = 0;
    ai = 0;
`ifdef COUNTER_IRQ_EN
    ei = m_irq;
    ai = int'(irq);
`endif
    n_vec++;
    if (int'(q) != m_q || int'(busy) != eb
        || int'(wrap) != m_wrap || int'(done) != ed
        || int'(cif.cmd_ready) != m_rdy || ai != ei) begin
      n_err++;
      $display("FAIL rand[%0d]: got q=%0d b=%0d w=%0d d=%0d r=%0d i=%0d expected q=%0d b=%0d w=%0d d=%0d r=%0d i=%0d",
               cyc_no, q, busy, wrap, done, cif.cmd_ready, ai,
               m_q, eb, m_wrap, ed, m_rdy, ei);
    end
  endtask

  typedef struct {
    bit         r;
    bit         v;
    logic [1:0] op;
    logic [3:0] lim;
    logic [7:0] dv;
    bit         one;
    int         eq;
    bit         eb;
    bit         ew;
    bit         ed;
    bit         er;
  } vec_t;

  vec_t tv[26];

  initial begin
    drive(1, 0, 2'd0, 4'd0, 8'd0, 0);

    // r v op lim div one | q busy wrap done ready
    tv[0]  = '{1, 0, 2'd0, 4'd0, 8'd0, 0, 0, 0, 0, 0, 1};
    tv[1]  = '{0, 1, 2'd0, 4'd5, 8'd0, 0, 0, 1, 0, 0, 0};
    tv[2]  = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 1, 1, 0, 0, 1};
    tv[3]  = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 2, 1, 0, 0, 1};
    tv[4]  = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 3, 1, 0, 0, 1};
    tv[5]  = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 4, 1, 0, 0, 1};
    tv[6]  = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 5, 1, 0, 0, 1};
    tv[7]  = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 0, 1, 1, 0, 1};
    tv[8]  = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 1, 1, 0, 0, 1};
    tv[9]  = '{0, 1, 2'd1, 4'd0, 8'd0, 0, 1, 0, 0, 0, 0};
    tv[10] = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 1, 0, 0, 0, 1};
    tv[11] = '{0, 1, 2'd2, 4'd0, 8'd0, 0, 2, 0, 0, 0, 0};
    tv[12] = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 2, 0, 0, 0, 1};
    tv[13] = '{0, 1, 2'd0, 4'd5, 8'd0, 0, 2, 1, 0, 0, 0};
    tv[14] = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 3, 1, 0, 0, 1};
    tv[15] = '{0, 1, 2'd3, 4'd0, 8'd0, 0, 0, 0, 0, 0, 0};
    tv[16] = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 0, 0, 0, 0, 1};
    tv[17] = '{0, 1, 2'd0, 4'd0, 8'd0, 0, 0, 1, 0, 0, 0};
    tv[18] = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 0, 1, 1, 0, 1};
    tv[19] = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 0, 1, 1, 0, 1};
    tv[20] = '{0, 1, 2'd1, 4'd0, 8'd0, 0, 0, 0, 0, 0, 0};
    tv[21] = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 0, 0, 0, 0, 1};
    tv[22] = '{0, 1, 2'd0, 4'd0, 8'd0, 1, 0, 1, 0, 0, 0};
    tv[23] = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 0, 0, 0, 1, 1};
    tv[24] = '{0, 1, 2'd2, 4'd0, 8'd0, 0, 0, 0, 0, 1, 0};
    tv[25] = '{0, 0, 2'd0, 4'd0, 8'd0, 0, 0, 0, 0, 1, 1};

    for (int i = 0; i < 26; i++) begin
      drive(tv[i].r, tv[i].v, tv[i].op, tv[i].lim,
            tv[i].dv, tv[i].one);
      cyc();
      n_vec++;
      if (int'(q) != tv[i].eq || busy != tv[i].eb
          || wrap != tv[i].ew || done != tv[i].ed
          || cif.cmd_ready != tv[i].er) begin
        n_err++;
        $display("FAIL vec[%0d]: got q=%0d b=%0d w=%0d d=%0d r=%0d expected q=%0d b=%0d w=%0d d=%0d r=%0d",
                 i, q, busy, wrap, done, cif.cmd_ready,
                 tv[i].eq, tv[i].eb, tv[i].ew, tv[i].ed,
                 tv[i].er);
      end
    end

    // one-shot with divider: tick every 3 cycles, DONE after q=3
    drive(1, 0, 2'd0, 4'd0, 8'd0, 0);
    cyc();
    drive(0, 1, 2'd0, 4'd3, 8'd2, 1);
    cyc();
    drive(0, 0, 2'd0, 4'd0, 8'd0, 0);
    for (int k = 1; k <= 13; k++) begin
      int eq;
      cyc();
      eq = (k / 3 > 3) ? 3 : k / 3;
      expect_eq($sformatf("oneshot_q[%0d]", k), int'(q), eq);
      expect_eq($sformatf("oneshot_done[%0d]", k),
                int'(done), (k >= 12) ? 1 : 0);
      expect_eq($sformatf("oneshot_busy[%0d]", k),
                int'(busy), (k >= 12) ? 0 : 1);
    end

    // held cmd_valid: one STEP accepted every two cycles
    drive(1, 0, 2'd0, 4'd0, 8'd0, 0);
    cyc();
    drive(0, 1, 2'd2, 4'd0, 8'd0, 0);
    for (int j = 1; j <= 6; j++) begin
      cyc();
      expect_eq($sformatf("b2b_q[%0d]", j), int'(q), (j + 1) / 2);
      expect_eq($sformatf("b2b_ready[%0d]", j),
                int'(cif.cmd_ready), (j % 2 == 0) ? 1 : 0);
    end

    // reset beats a command in the same cycle
    drive(1, 0, 2'd0, 4'd0, 8'd0, 0);
    cyc();
    drive(0, 1, 2'd0, 4'd9, 8'd0, 0);
    cyc();
    drive(0, 0, 2'd0, 4'd0, 8'd0, 0);
    for (int j = 0; j < 4; j++) cyc();
    expect_eq("midrun_q", int'(q), 4);
    drive(1, 1, 2'd0, 4'd9, 8'd0, 0);
    cyc();
    expect_eq("rst_q", int'(q), 0);
    expect_eq("rst_busy", int'(busy), 0);
    expect_eq("rst_wrap", int'(wrap), 0);
    expect_eq("rst_done", int'(done), 0);
    expect_eq("rst_ready", int'(cif.cmd_ready), 1);

`ifdef COUNTER_IRQ_EN
    drive(0, 1, 2'd0, 4'd1, 8'd0, 0);
    cyc();
    drive(0, 0, 2'd0, 4'd0, 8'd0, 0);
    expect_eq("irq_idle", int'(irq), 0);
    cyc();
    cyc();
    expect_eq("irq_wrap", int'(wrap), 1);
    expect_eq("irq_set", int'(irq), 1);
    drive(0, 1, 2'd3, 4'd0, 8'd0, 0);
    cyc();
    drive(0, 0, 2'd0, 4'd0, 8'd0, 0);
    expect_eq("irq_clr", int'(irq), 0);
`endif

    // random commands against the model
    drive(1, 0, 2'd0, 4'd0, 8'd0, 0);
    cyc();
    for (int c = 0; c < 4000; c++) begin
      int sel;
      logic [1:0] op;
      sel = int'($urandom_range(0, 9));
      if (sel < 4 || sel == 9) op = 2'd0;
      else if (sel < 6)        op = 2'd1;
      else if (sel < 8)        op = 2'd2;
      else                     op = 2'd3;
      drive($urandom_range(0, 199) == 0,
            1'($urandom_range(0, 1)), op,
            4'($urandom_range(0, QMOD - 1)),
            8'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      cyc();
      chk_model(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
